// File: rtl/float_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : float_mul_pkg
//  Brief    : Shared FPU definitions: rounding modes, special encodings,
//             operand class bits and small helper functions.
//  Revision : 1.0 - initial release
// ============================================================================
package float_mul_pkg;

    // Rounding-mode encoding shared with the pipelined divider
    localparam logic [1:0] RM_RNE = 2'b00;  // nearest, ties to even
    localparam logic [1:0] RM_RD  = 2'b01;  // toward -inf
    localparam logic [1:0] RM_RU  = 2'b10;  // toward +inf
    localparam logic [1:0] RM_RZ  = 2'b11;  // toward zero

    // Special single-precision encodings (sign bit cleared)
    localparam logic [31:0] ZERO    = 32'h0000_0000;
    localparam logic [31:0] INF     = 32'h7F80_0000;
    localparam logic [31:0] MAX     = 32'h7F7F_FFFF;
    localparam logic [31:0] NAN_VAL = 32'h7FC0_0000;

    // Operand class bits: exponent all-zero, exponent all-one, fraction zero
    typedef struct packed {
        logic e00;
        logic eff;
        logic f00;
    } fp_class_t;

    function automatic fp_class_t classify(input logic [31:0] x);
        fp_class_t c;
        c.e00 = (x[30:23] == 8'h00);
        c.eff = (x[30:23] == 8'hFF);
        c.f00 = (x[22:0] == 23'd0);
        return c;
    endfunction

    // Rounding increment from guard/round/sticky and the kept LSB
    function automatic logic round_inc(input logic [1:0] rm, input logic sign,
                                       input logic lsb, input logic g,
                                       input logic r, input logic st);
        logic inc;
        case (rm)
            RM_RNE:  inc = g & (r | st | lsb);
            RM_RD:   inc = (g | r | st) & sign;
            RM_RU:   inc = (g | r | st) & ~sign;
            RM_RZ:   inc = 1'b0;
            default: inc = 1'b0;
        endcase
        return inc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/float_mul_shift_to_msb_equ_1.sv
`default_nettype none
// ============================================================================
//  Module   : shift_to_msb_equ_1
//  Brief    : Left-normalises a 24-bit significand so its MSB is 1 and
//             reports the shift amount (0..23). An all-zero input reports 23;
//             callers treat zero operands as a special case.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_to_msb_equ_1 (
    input  logic [23:0] i_din,
    output logic [23:0] o_dout,
    output logic [4:0]  o_sh
);

    // Find the highest set bit; scanning upward leaves the last hit in o_sh
    always_comb begin
        o_sh = 5'd23;
        for (int i = 0; i < 24; i++) begin
            if (i_din[i]) o_sh = 5'(23 - i);
        end
        o_dout = i_din << o_sh;
    end

endmodule
`default_nettype wire

// File: rtl/float_mul.sv
`default_nettype none
// ============================================================================
//  Module   : float_mul
//  Brief    : Pipelined IEEE-754 single-precision multiplier.
//             Stage 1 holds unpacked/normalised operands, stage 2 the 48-bit
//             significand product, stage 3 the normalised value with
//             guard/round/sticky; the output register rounds and packs.
//             Result appears 3 advancing edges after capture; busy covers the
//             three internal stages.
//  Revision : 1.0 - initial release
// ============================================================================
module float_mul #(
    parameter int unsigned STAGES  = 3,
    parameter logic [31:0] NAN_VAL = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        fmul,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  rm,
    output logic [31:0] s,
    output logic        s_valid,
    output logic        busy
);
    import float_mul_pkg::*;

    // ------------------------------------------------------------------
    // E1: classify and unpack
    // ------------------------------------------------------------------
    fp_class_t   w_ca, w_cb;
    logic [23:0] w_ma_raw, w_mb_raw, w_ma_n, w_mb_n;
    logic [4:0]  w_sh_a, w_sh_b;
    logic [9:0]  w_e1;

    assign w_ca = classify(a);
    assign w_cb = classify(b);

    // Subnormals carry the fraction one place up so the exponent base is 0
    assign w_ma_raw = w_ca.e00 ? {a[22:0], 1'b0} : {1'b1, a[22:0]};
    assign w_mb_raw = w_cb.e00 ? {b[22:0], 1'b0} : {1'b1, b[22:0]};

    shift_to_msb_equ_1 u_norm_a (
        .i_din  (w_ma_raw),
        .o_dout (w_ma_n),
        .o_sh   (w_sh_a)
    );

    shift_to_msb_equ_1 u_norm_b (
        .i_din  (w_mb_raw),
        .o_dout (w_mb_n),
        .o_sh   (w_sh_b)
    );

    assign w_e1 = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127
                - {5'b00000, w_sh_a} - {5'b00000, w_sh_b};

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic [STAGES-1:0] r_vld;

    logic        r_s1_sign;
    logic [1:0]  r_s1_rm;
    logic [9:0]  r_s1_e;
    logic [23:0] r_s1_ma, r_s1_mb;
    fp_class_t   r_s1_ca, r_s1_cb;

    logic        r_s2_sign;
    logic [1:0]  r_s2_rm;
    logic [9:0]  r_s2_e;
    logic [47:0] r_s2_p;
    fp_class_t   r_s2_ca, r_s2_cb;

    logic        r_s3_sign;
    logic [1:0]  r_s3_rm;
    logic [9:0]  r_s3_e;
    logic [23:0] r_s3_sig;
    logic        r_s3_g, r_s3_r, r_s3_st;
    logic        r_s3_nan, r_s3_inf, r_s3_zero;

    // ------------------------------------------------------------------
    // E3a: normalise the product and denormalise on underflow
    // ------------------------------------------------------------------
    logic [25:0] w_x;       // {sig[23:0], guard, round}
    logic        w_st;
    logic [9:0]  w_en;
    logic [5:0]  w_k;
    logic [51:0] w_ext;
    logic        w_nan, w_inf, w_zero;

    // Pick the product window, then right-shift into the subnormal range
    always_comb begin
        w_x   = '0;
        w_st  = 1'b0;
        w_en  = r_s2_e;
        w_k   = '0;
        w_ext = '0;
        if (r_s2_p[47]) begin
            w_x  = r_s2_p[47:22];
            w_st = |r_s2_p[21:0];
            w_en = r_s2_e + 10'd1;
        end else begin
            w_x  = r_s2_p[46:21];
            w_st = |r_s2_p[20:0];
        end
        if ($signed(w_en) <= 0) begin
            // Shifts of 26 or more push every kept bit into sticky
            if ($signed(w_en) < -10'sd25) w_k = 6'd26;
            else                          w_k = 6'(10'd1 - w_en);
            w_ext = {w_x, 26'd0} >> w_k;
            w_x   = w_ext[51:26];
            w_st  = w_st | (|w_ext[25:0]);
            w_en  = '0;
        end
    end

    // Special-value flags; NaN outranks inf, inf outranks zero
    assign w_nan  = (r_s2_ca.eff & ~r_s2_ca.f00) | (r_s2_cb.eff & ~r_s2_cb.f00)
                  | (r_s2_ca.eff & r_s2_ca.f00 & r_s2_cb.e00 & r_s2_cb.f00)
                  | (r_s2_cb.eff & r_s2_cb.f00 & r_s2_ca.e00 & r_s2_ca.f00);
    assign w_inf  = (r_s2_ca.eff & r_s2_ca.f00) | (r_s2_cb.eff & r_s2_cb.f00);
    assign w_zero = (r_s2_ca.e00 & r_s2_ca.f00) | (r_s2_cb.e00 & r_s2_cb.f00);

    // ------------------------------------------------------------------
    // E3b: round, detect overflow, apply specials, pack
    // ------------------------------------------------------------------
    logic        w_inc;
    logic [24:0] w_sum;
    logic [9:0]  w_exp;
    logic        w_ovf_inf;
    logic [31:0] w_res;

    // Round the kept significand and build the final encoding
    always_comb begin
        w_inc = round_inc(r_s3_rm, r_s3_sign, r_s3_sig[0], r_s3_g, r_s3_r, r_s3_st);
        w_sum = {1'b0, r_s3_sig} + {24'd0, w_inc};
        // Carry-out bumps the exponent; a subnormal reaching 1.0 becomes exp 1
        w_exp = r_s3_e + {9'd0, w_sum[24] | ((r_s3_e == 10'd0) & w_sum[23])};
        w_ovf_inf = (r_s3_rm == RM_RNE)
                  | ((r_s3_rm == RM_RU) & ~r_s3_sign)
                  | ((r_s3_rm == RM_RD) &  r_s3_sign);
        w_res = {r_s3_sign, w_exp[7:0], w_sum[22:0]};
        if (r_s3_nan) begin
            w_res = NAN_VAL;
        end else if (r_s3_inf) begin
            w_res = {r_s3_sign, INF[30:0]};
        end else if (r_s3_zero) begin
            w_res = {r_s3_sign, ZERO[30:0]};
        end else if (w_exp >= 10'd255) begin
            w_res = w_ovf_inf ? {r_s3_sign, INF[30:0]} : {r_s3_sign, MAX[30:0]};
        end
    end

    // Advance all stages together on en; reset clears every stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld     <= '0;
            r_s1_sign <= 1'b0;
            r_s1_rm   <= '0;
            r_s1_e    <= '0;
            r_s1_ma   <= '0;
            r_s1_mb   <= '0;
            r_s1_ca   <= '0;
            r_s1_cb   <= '0;
            r_s2_sign <= 1'b0;
            r_s2_rm   <= '0;
            r_s2_e    <= '0;
            r_s2_p    <= '0;
            r_s2_ca   <= '0;
            r_s2_cb   <= '0;
            r_s3_sign <= 1'b0;
            r_s3_rm   <= '0;
            r_s3_e    <= '0;
            r_s3_sig  <= '0;
            r_s3_g    <= 1'b0;
            r_s3_r    <= 1'b0;
            r_s3_st   <= 1'b0;
            r_s3_nan  <= 1'b0;
            r_s3_inf  <= 1'b0;
            r_s3_zero <= 1'b0;
        end else if (en) begin
            r_vld <= {r_vld[STAGES-2:0], fmul};
            if (fmul) begin
                r_s1_sign <= a[31] ^ b[31];
                r_s1_rm   <= rm;
                r_s1_e    <= w_e1;
                r_s1_ma   <= w_ma_n;
                r_s1_mb   <= w_mb_n;
                r_s1_ca   <= w_ca;
                r_s1_cb   <= w_cb;
            end
            r_s2_sign <= r_s1_sign;
            r_s2_rm   <= r_s1_rm;
            r_s2_e    <= r_s1_e;
            r_s2_p    <= {24'd0, r_s1_ma} * {24'd0, r_s1_mb};
            r_s2_ca   <= r_s1_ca;
            r_s2_cb   <= r_s1_cb;
            r_s3_sign <= r_s2_sign;
            r_s3_rm   <= r_s2_rm;
            r_s3_e    <= w_en;
            r_s3_sig  <= w_x[25:2];
            r_s3_g    <= w_x[1];
            r_s3_r    <= w_x[0];
            r_s3_st   <= w_st;
            r_s3_nan  <= w_nan;
            r_s3_inf  <= w_inf;
            r_s3_zero <= w_zero;
        end
    end

    // Output register; s holds its last value across bubbles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s       <= '0;
            s_valid <= 1'b0;
        end else if (en) begin
            s_valid <= r_vld[STAGES-1];
            if (r_vld[STAGES-1]) s <= w_res;
        end
    end

    assign busy = |r_vld;

endmodule
`default_nettype wire

// File: doc/float_mul.md
Name: float_mul

Overview:
- 3-stage pipelined IEEE-754 single-precision multiplier for the FPU datapath. It is the companion to the pipelined divider.
- Shares the divider's 2-bit rounding-mode encoding, enable/stall convention and special-value policy, so the FPU result mux can treat both units the same way.
- Accepts one operation per cycle when the pipeline advances. Produces a registered result with a valid flag 3 advancing cycles later.

Parameters:
- STAGES, 3, pipeline depth. Fixed; any other value is unsupported.
- NAN_VAL, 32'h7FC00000, canonical quiet NaN emitted for every invalid result.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- en  in  1  pipeline advance; when 0, every stage register holds its value.
- fmul  in  1  operation valid; a, b and rm are captured when fmul & en.
- a  in  32  multiplicand, IEEE single.
- b  in  32  multiplier, IEEE single.
- rm  in  2  rounding mode: 00 nearest-even, 01 toward -inf, 10 toward +inf, 11 toward zero.
- s  out  32  product; registered.
- s_valid  out  1  s holds the result of a captured operation.
- busy  out  1  OR of the valid bits of all 3 stages.

Behaviour:
- Reset: every stage register clears to 0, including valid bits; s=0, s_valid=0, busy=0.
  - Reset takes priority over en.
  - An operation in flight at reset is discarded; no partial result appears.
- Pipeline: each stage carries a valid bit. On clk with en=1, every stage loads from the previous one; stage-1 valid loads fmul.
  - Result for inputs captured at edge N appears at edge N+3 when en=1 throughout.
  - en=0 freezes all stages, s and s_valid. Inputs are ignored while frozen.
  - A bubble (fmul=0) propagates as s_valid=0. s keeps its last value while s_valid=0.
- E1, unpack:
  - sign = a[31]^b[31].
  - Classify each operand: exp==00, exp==FF, frac==0.
  - Significand: normal {1,frac}; subnormal {frac,0}. Left-normalise so the MSB is 1 and record shift amount sh (0..23).
  - Exponent, 10-bit two's complement: e = ea + eb - 127 - sh_a - sh_b.
  - Register classes, sign, rm, e and both 24-bit significands.
- E2, multiply: 48-bit product p = ma*mb, so p[47:46] != 00. Register p and carry the other E1 fields forward.
- E3, normalise, round and pack:
  - If p[47]=1, e+1 and use p[47:23]. Otherwise use p[46:22].
  - Keep guard, round and sticky bits, where sticky is the OR of all lower bits.
  - If e <= 0: right-shift by 1-e, OR all bits shifted out into sticky, and set e=0. Shifts >= 26 leave only sticky.
  - Rounding increment:
    - RNE: G&(R|S|L).
    - RD: (G|R|S)&sign.
    - RU: (G|R|S)&~sign.
    - RZ: 0.
  - A rounding carry-out adds 1 to e; a subnormal that rounds up to 1.0 becomes exponent 1.
  - Overflow when e >= 255:
    - RNE: inf.
    - RZ: max (7F7FFFFF).
    - RU: positive gives inf, negative gives max.
    - RD: negative gives inf, positive gives max.
    - The sign bit is always applied.
- Special cases override the computed result, in this priority:
  - Any NaN operand gives NAN_VAL.
  - inf*0 gives NAN_VAL.
  - inf*x gives signed inf.
  - 0*x gives signed zero.
  - NaN outputs ignore the computed sign.
- An exact zero never arises from finite nonzero operands except by underflow. Underflow yields signed zero or min-subnormal according to rm.

Decomposition:
- Shared fpu package holds:
  - rounding-mode constants RM_RNE, RM_RD, RM_RU, RM_RZ;
  - constants ZERO, INF, MAX, NAN_VAL;
  - the class-bits struct {e00, eff, f00}.
- Reuse shift_to_msb_equ_1 as the E1 normaliser; instantiate it once per operand.
- The rest is one module with no further sub-modules.

Test Plan:
- 3FC00000*40000000, rm=00, en=1 → s=40400000 with s_valid 3 cycles after capture; busy high for 3 cycles.
- 3F800001*3F800001 → s=3F800002 (rm=00), 3F800003 (rm=10), 3F800002 (rm=11).
- 7F7FFFFF*40000000 → 7F800000 (rm=00), 7F7FFFFF (rm=11); with a negated → FF800000 (rm=01), FF7FFFFF (rm=10).
- 00800000*3F000000 → 00400000. 00000001*3F000000, rm=00 → 00000000; rm=10 → 00000001.
- 7F800000*00000000 → 7FC00000. FF800000*3F800000 → FF800000. 80000000*40000000 → 80000000.
- Back-to-back issue of 3 ops with en=0 for 2 cycles mid-stream → results in order, none lost or duplicated. rst_n=0 with ops in flight → s=0, s_valid=0, busy=0 on the next edge.
